mem_access_unit: RTL and testbench

- MEM-stage load/store engine between the EX/MEM pipeline register and the MEM/WB register.
- Takes the effective address (ALU result), store data (rs2) and funct3, and runs a req/ack transaction on a 64-bit data-memory port.
- Produces sign/zero-extended load data for MEM/WB's rdata input.
- Stalls the pipeline while a transaction is outstanding, and flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives one req/ack transaction per access and returns extended load data.
// Latency: 3 cycles minimum (IDLE issue, WAIT with ack, DONE); misaligned accesses take 2 (IDLE, DONE).
// Backpressure: stall holds the upstream pipeline from the start cycle until ack or timeout; stall is 0 in DONE.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bus-side fields captured at issue and held stable for the whole WAIT phase.
    typedef struct packed {
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
    } bus_req_t;

    state_t        state;
    state_t        state_nxt;
    bus_req_t      bus_q;
    bus_req_t      bus_d;
    logic [2:0]    f3_q;
    logic [2:0]    off_q;
    logic [CW-1:0] cnt;
    logic          start;
    logic          aligned;
    logic [7:0]    size_mask;
    logic          capture;
    logic          ld_done;
    logic          fault;
    logic          timeout_hit;
    logic [63:0]   rd_shift;

    // Sign/zero extension of the lane-aligned read data; D (and code 7) passes through.
    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] v);
        case (f3)
            3'd0:    return {{56{v[7]}}, v[7:0]};
            3'd1:    return {{48{v[15]}}, v[15:0]};
            3'd2:    return {{32{v[31]}}, v[31:0]};
            3'd4:    return {56'd0, v[7:0]};
            3'd5:    return {48'd0, v[15:0]};
            3'd6:    return {32'd0, v[31:0]};
            default: return v;
        endcase
    endfunction

    assign dmem_req   = (state == WAIT);
    assign dmem_we    = bus_q.we;
    assign dmem_be    = bus_q.be;
    assign dmem_addr  = bus_q.addr;
    assign dmem_wdata = bus_q.wdata;
    assign rd_shift   = dmem_rdata >> {off_q, 3'b000};

    // Decode size, alignment and the lane-shifted bus fields of the presented op.
    always_comb begin
        start     = mem_rd | mem_wr;
        size_mask = 8'h01;
        aligned   = 1'b1;
        case (funct3[1:0])
            2'd0: begin size_mask = 8'h01; aligned = 1'b1;                end
            2'd1: begin size_mask = 8'h03; aligned = ~addr[0];            end
            2'd2: begin size_mask = 8'h0F; aligned = (addr[1:0] == 2'd0); end
            default: begin size_mask = 8'hFF; aligned = (addr[2:0] == 3'd0); end
        endcase
        // A simultaneous rd+wr is a store.
        bus_d.we    = mem_wr;
        bus_d.be    = size_mask << addr[2:0];
        bus_d.addr  = {addr[63:3], 3'b000};
        bus_d.wdata = wdata << {addr[2:0], 3'b000};
    end

    // Next-state and control strobes; DONE ignores inputs since the same op is still presented.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        fault       = 1'b0;
        ld_done     = 1'b0;
        timeout_hit = 1'b0;
        stall       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall = 1'b1;
                    if (aligned) begin
                        capture   = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        fault     = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    ld_done   = ~bus_q.we;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops dmem_req at the reset edge by returning to IDLE.
    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Captured bus request, load result, one-cycle fault pulses and the WAIT timeout counter.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            bus_q    <= '0;
            f3_q     <= 3'd0;
            off_q    <= 3'd0;
            rdata    <= 64'd0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            cnt      <= '0;
        end else begin
            if (capture) begin
                bus_q <= bus_d;
                f3_q  <= funct3;
                off_q <= addr[2:0];
            end
            if (ld_done) rdata <= extend(f3_q, rd_shift);
            misalign <= fault;
            bus_err  <= timeout_hit;
            if (state == WAIT && !dmem_ack && !timeout_hit) cnt <= cnt + CW'(1);
            else if (state == DONE)                          cnt <= '0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a responding memory and an expected-result queue.
// Latency: each op runs until the DUT's DONE cycle (first stall-low cycle after issue).
// Backpressure: bench holds the op on the inputs while stall is high and through DONE.
module tb_mem_access_unit;
    logic        clk;
    logic        nrst;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic [63:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic        we;
        logic [7:0]  be;
        logic [63:0] baddr;
        logic [63:0] bwdata;
        logic [63:0] rdata;
        int          stall_n;
        int          req_n;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb[$];

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .rdata      (rdata),
        .stall      (stall),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic we, input logic [7:0] be,
                                input logic [63:0] ba, input logic [63:0] bw, input logic [63:0] rd,
                                input int st, input int rq, input logic mis, input logic berr);
        exp_t e;
        e.tag = tag; e.we = we; e.be = be; e.baddr = ba; e.bwdata = bw; e.rdata = rd;
        e.stall_n = st; e.req_n = rq; e.mis = mis; e.berr = berr;
        return e;
    endfunction

    // Present one op, answer from memory with ack on WAIT cycle ack_at+1 (ack_at<0: never),
    // then pop the expected result at the DONE cycle and compare.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] mem_dat, input int ack_at);
        int          stall_n = 0;
        int          req_n   = 0;
        int          cyc     = 0;
        logic        done    = 1'b0;
        logic        stable  = 1'b1;
        logic        g_we    = 1'b0;
        logic [7:0]  g_be    = 8'd0;
        logic [63:0] g_addr  = 64'd0;
        logic [63:0] g_wdata = 64'd0;
        exp_t        e;
        mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        while (!done && cyc < 60) begin
            dmem_ack = 1'b0;
            if (stall) begin
                stall_n++;
                if (dmem_req) begin
                    req_n++;
                    if (req_n == 1) begin
                        g_we = dmem_we; g_be = dmem_be; g_addr = dmem_addr; g_wdata = dmem_wdata;
                    end else if (g_we !== dmem_we || g_be !== dmem_be ||
                                 g_addr !== dmem_addr || g_wdata !== dmem_wdata) begin
                        stable = 1'b0;
                    end
                    dmem_rdata = mem_dat;
                    dmem_ack   = (req_n == ack_at + 1);
                end
                @(posedge clk); #1;
                cyc++;
            end else begin
                done = 1'b1;
            end
        end
        dmem_ack = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty_at_done", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_done_reached"}, 64'(done), 64'd1);
            chk({e.tag, "_rdata"}, rdata, e.rdata);
            chk({e.tag, "_misalign"}, 64'(misalign), 64'(e.mis));
            chk({e.tag, "_bus_err"}, 64'(bus_err), 64'(e.berr));
            chk({e.tag, "_stall_cycles"}, 64'(stall_n), 64'(e.stall_n));
            chk({e.tag, "_req_cycles"}, 64'(req_n), 64'(e.req_n));
            if (e.req_n > 0) begin
                chk({e.tag, "_we"}, 64'(g_we), 64'(e.we));
                chk({e.tag, "_be"}, 64'(g_be), 64'(e.be));
                chk({e.tag, "_dmem_addr"}, g_addr, e.baddr);
                chk({e.tag, "_dmem_wdata"}, g_wdata, e.bwdata);
                chk({e.tag, "_bus_stable"}, 64'(stable), 64'd1);
            end
            // Pipeline advances at the DONE edge; pulses must be gone and stall low in IDLE.
            @(posedge clk); #1;
            mem_rd = 1'b0; mem_wr = 1'b0;
            #1;
            chk({e.tag, "_pulse_end"}, {62'd0, misalign, bus_err}, 64'd0);
            chk({e.tag, "_idle_stall"}, 64'(stall), 64'd0);
        end
    endtask

    initial begin
        int cyc;
        nrst = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'd0;
        addr = 64'd0; wdata = 64'd0; dmem_ack = 1'b0; dmem_rdata = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_we", 64'(dmem_we), 64'd0);
        chk("rst_be", 64'(dmem_be), 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wdata", dmem_wdata, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_pulses", {62'd0, misalign, bus_err}, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        sb.push_back(mk("lw", 1'b0, 8'hF0, 64'h1000, 64'd0, 64'hFFFF_FFFF_8000_0000, 4, 3, 1'b0, 1'b0));
        do_op(1'b1, 1'b0, 3'd2, 64'h1004, 64'd0, 64'h8000_0000_0000_0000, 2);

        sb.push_back(mk("sh", 1'b1, 8'hC0, 64'h2000, 64'hBEEF_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 2, 1, 1'b0, 1'b0));
        do_op(1'b0, 1'b1, 3'd1, 64'h2006, 64'h0000_0000_0000_BEEF, 64'd0, 0);

        sb.push_back(mk("sb", 1'b1, 8'h80, 64'h1000, 64'hAB00_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 2, 1, 1'b0, 1'b0));
        do_op(1'b0, 1'b1, 3'd0, 64'h1007, 64'h0000_0000_0000_00AB, 64'd0, 0);

        sb.push_back(mk("lbu", 1'b0, 8'h08, 64'h3000, 64'd0, 64'h0000_0000_0000_00A5, 3, 2, 1'b0, 1'b0));
        do_op(1'b1, 1'b0, 3'd4, 64'h3003, 64'd0, 64'h0123_4567_A5BC_DEF0, 1);

        sb.push_back(mk("lb", 1'b0, 8'h08, 64'h3000, 64'd0, 64'hFFFF_FFFF_FFFF_FFA5, 3, 2, 1'b0, 1'b0));
        do_op(1'b1, 1'b0, 3'd0, 64'h3003, 64'd0, 64'h0123_4567_A5BC_DEF0, 1);

        sb.push_back(mk("ld_mis", 1'b0, 8'h00, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFA5, 1, 0, 1'b1, 1'b0));
        do_op(1'b1, 1'b0, 3'd3, 64'h4004, 64'd0, 64'hDEAD_BEEF_DEAD_BEEF, 0);

        sb.push_back(mk("lh_mis", 1'b0, 8'h00, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFA5, 1, 0, 1'b1, 1'b0));
        do_op(1'b1, 1'b0, 3'd1, 64'h5001, 64'd0, 64'hDEAD_BEEF_DEAD_BEEF, 0);

        sb.push_back(mk("lhu", 1'b0, 8'hC0, 64'h5000, 64'd0, 64'h0000_0000_0000_8001, 2, 1, 1'b0, 1'b0));
        do_op(1'b1, 1'b0, 3'd5, 64'h5006, 64'd0, 64'h8001_0000_0000_0000, 0);

        sb.push_back(mk("sd_rdwr_f7", 1'b1, 8'hFF, 64'h6000, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_8001, 2, 1, 1'b0, 1'b0));
        do_op(1'b1, 1'b1, 3'd7, 64'h6000, 64'h1122_3344_5566_7788, 64'd0, 0);

        sb.push_back(mk("lw_timeout", 1'b0, 8'h0F, 64'h7000, 64'd0, 64'h0000_0000_0000_8001, 17, 16, 1'b0, 1'b1));
        do_op(1'b1, 1'b0, 3'd2, 64'h7000, 64'd0, 64'h5555_5555_5555_5555, -1);

        sb.push_back(mk("lh_after_to", 1'b0, 8'h0C, 64'h7000, 64'd0, 64'h0000_0000_0000_7FFF, 2, 1, 1'b0, 1'b0));
        do_op(1'b1, 1'b0, 3'd1, 64'h7002, 64'd0, 64'h0000_0000_7FFF_0000, 0);

        // Reset while WAIT is outstanding, then a late ack that must be ignored.
        mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'd2; addr = 64'h8000; wdata = 64'd0;
        #1;
        cyc = 0;
        while (!dmem_req && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rstw_req_seen", 64'(dmem_req), 64'd1);
        @(posedge clk); #1;
        nrst = 1'b0;
        @(posedge clk); #1;
        chk("rstw_req_drop", 64'(dmem_req), 64'd0);
        mem_rd = 1'b0; nrst = 1'b1;
        dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rstw_late_ack_rdata", rdata, 64'd0);
        chk("rstw_late_ack_req", 64'(dmem_req), 64'd0);
        chk("rstw_late_ack_stall", 64'(stall), 64'd0);
        chk("rstw_late_ack_pulses", {62'd0, misalign, bus_err}, 64'd0);

        sb.push_back(mk("lwu_after_rst", 1'b0, 8'hF0, 64'h9000, 64'd0, 64'h0000_0000_89AB_CDEF, 3, 2, 1'b0, 1'b0));
        do_op(1'b1, 1'b0, 3'd6, 64'h9004, 64'd0, 64'h89AB_CDEF_0000_0000, 1);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
